// File: rtl/inst_fetch_pkg.sv
// Shared pipeline definitions: reset PC, NOP encoding and the branch prediction record.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] alt_addr;
    } pred_rec_t;

endpackage

// File: rtl/inst_fetch_pred_queue.sv
// Synchronous FIFO of outstanding branch predictions, oldest record exposed at the head.
module pred_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  pred_rec_t wr_data,
    output pred_rec_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    pred_rec_t     mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; a slot is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, IF/ID register and decode-time branch prediction with EX-time recovery.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          RQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        id_jmp,
    input  logic        id_is_branch,
    input  logic [31:0] id_target,
    input  logic        ex_resolve,
    input  logic        ex_taken,
    output logic [31:0] if_inst_addr,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        flush_o,
    output logic        stall_req_o,
    output logic        pred_err_o
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    pred_rec_t   head;
    pred_rec_t   new_rec;
    logic        q_full;
    logic        q_empty;
    logic        branch_in_id;
    logic        mispredict;
    logic        push;
    logic        pop;
    logic        hold;
    logic        redirect_id;

    assign imem_addr    = pc;
    assign branch_in_id = id_is_branch && if_valid;
    assign mispredict   = ex_resolve && !q_empty && (ex_taken != head.pred_taken);
    assign pop          = ex_resolve && !q_empty;
    assign stall_req_o  = q_full && branch_in_id;
    assign push         = branch_in_id && !stall_i && !q_full && !mispredict;
    assign hold         = stall_i || stall_req_o;
    assign redirect_id  = id_jmp && if_valid;

    // The record stores the path not taken, so recovery is a single PC load.
    assign new_rec.pred_taken = id_jmp;
    assign new_rec.alt_addr   = id_jmp ? (if_inst_addr + 32'd4) : id_target;

    pred_queue #(.DEPTH(RQ_DEPTH)) u_pred_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .clear   (mispredict),
        .wr_data (new_rec),
        .head    (head),
        .full    (q_full),
        .empty   (q_empty)
    );

    // NOTE: next_pc gets a default before any branch so no latch can be inferred.
    always_comb begin
        next_pc = pc + 32'd4;
        if (mispredict)       next_pc = head.alt_addr;
        else if (hold)        next_pc = pc;
        else if (redirect_id) next_pc = id_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            if_inst_addr <= '0;
            if_inst      <= NOP_INST;
            if_valid     <= 1'b0;
        end else begin
            pc <= next_pc;
            if (mispredict || (redirect_id && !hold)) begin
                if_valid <= 1'b0;
            end else if (!hold) begin
                if_inst_addr <= pc;
                if_inst      <= imem_rdata;
                if_valid     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_o    <= 1'b0;
            pred_err_o <= 1'b0;
        end else begin
            flush_o    <= mispredict;
            pred_err_o <= pred_err_o || (ex_resolve && q_empty);
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, prediction, mispredict, queue full, error and reset.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_jmp;
    logic        id_is_branch;
    logic [31:0] id_target;
    logic        ex_resolve;
    logic        ex_taken;
    logic [31:0] if_inst_addr;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        flush_o;
    logic        stall_req_o;
    logic        pred_err_o;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000), .RQ_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .id_jmp       (id_jmp),
        .id_is_branch (id_is_branch),
        .id_target    (id_target),
        .ex_resolve   (ex_resolve),
        .ex_taken     (ex_taken),
        .if_inst_addr (if_inst_addr),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
        .flush_o      (flush_o),
        .stall_req_o  (stall_req_o),
        .pred_err_o   (pred_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; imem_rdata = '0;
        id_jmp = 1'b0; id_is_branch = 1'b0; id_target = '0;
        ex_resolve = 1'b0; ex_taken = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_pc",    imem_addr,    32'h0);
        check("rst_valid", if_valid,     32'h0);
        check("rst_inst",  if_inst,      32'h13);
        check("rst_iaddr", if_inst_addr, 32'h0);
        check("rst_flush", flush_o,      32'h0);
        check("rst_err",   pred_err_o,   32'h0);

        // Sequential fetch from RESET_PC
        rst = 1'b0; imem_rdata = 32'h11; tick();
        check("seq0_iaddr", if_inst_addr, 32'h0);
        check("seq0_inst",  if_inst,      32'h11);
        check("seq0_valid", if_valid,     32'h1);
        imem_rdata = 32'h22; tick();
        check("seq1_iaddr", if_inst_addr, 32'h4);
        check("seq1_inst",  if_inst,      32'h22);
        imem_rdata = 32'h33; tick();
        check("seq2_iaddr", if_inst_addr, 32'h8);
        check("seq2_inst",  if_inst,      32'h33);
        check("seq2_pc",    imem_addr,    32'hc);
        imem_rdata = 32'h44; tick();
        imem_rdata = 32'h63; tick();
        check("br_in_id", if_inst_addr, 32'h10);

        // Taken prediction at 0x10 -> 0x40, one bubble, record {1,0x14}
        id_is_branch = 1'b1; id_jmp = 1'b1; id_target = 32'h40; imem_rdata = 32'h55;
        check("pre_jmp_pc", imem_addr, 32'h14);
        tick();
        check("jmp_pc",     imem_addr, 32'h40);
        check("jmp_bubble", if_valid,  32'h0);
        id_is_branch = 1'b0; id_jmp = 1'b0; id_target = '0; imem_rdata = 32'h66;
        tick();
        check("tgt_iaddr", if_inst_addr, 32'h40);
        check("tgt_valid", if_valid,     32'h1);
        check("tgt_pc",    imem_addr,    32'h44);

        // Mispredict overrides stall_i; same-cycle push suppressed
        stall_i = 1'b1; ex_resolve = 1'b1; ex_taken = 1'b0; id_is_branch = 1'b1;
        tick();
        stall_i = 1'b0; ex_resolve = 1'b0; id_is_branch = 1'b0;
        check("mp_pc",    imem_addr, 32'h14);
        check("mp_valid", if_valid,  32'h0);
        check("mp_flush", flush_o,   32'h1);
        imem_rdata = 32'h77; tick();
        check("mp_flush_once", flush_o,      32'h0);
        check("mp_iaddr",      if_inst_addr, 32'h14);
        check("mp_pc_next",    imem_addr,    32'h18);

        // Resolve on empty queue: error flag, PC unaffected
        ex_resolve = 1'b1; ex_taken = 1'b1; tick();
        ex_resolve = 1'b0;
        check("err_set",   pred_err_o, 32'h1);
        check("err_pc",    imem_addr,  32'h1c);
        check("err_flush", flush_o,    32'h0);
        tick();
        check("err_sticky", pred_err_o,   32'h1);
        check("err_pc2",    imem_addr,    32'h20);
        check("err_iaddr",  if_inst_addr, 32'h1c);

        // Fill the queue with four not-taken branches (alt = id_target)
        id_is_branch = 1'b1; id_jmp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            id_target = 32'h100 + 32'(i) * 32'h10;
            tick();
        end
        id_target = 32'h140;
        check("full_stall_req", stall_req_o,  32'h1);
        check("full_pc",        imem_addr,    32'h30);
        check("full_iaddr",     if_inst_addr, 32'h2c);
        tick();
        check("full_hold_pc",    imem_addr,    32'h30);
        check("full_hold_iaddr", if_inst_addr, 32'h2c);
        check("full_hold_valid", if_valid,     32'h1);

        // Correct resolve while full: pop now, 5th branch pushes next cycle
        ex_resolve = 1'b1; ex_taken = 1'b0;
        check("pop_stall_req", stall_req_o, 32'h1);
        tick();
        ex_resolve = 1'b0;
        check("pop_pc_held",   imem_addr,   32'h30);
        check("pop_stall_rel", stall_req_o, 32'h0);
        tick();
        check("push5_iaddr",  if_inst_addr, 32'h30);
        check("push5_pc",     imem_addr,    32'h34);
        check("push5_full",   stall_req_o,  32'h1);

        // Mispredict on new head (branch 0x20, alt 0x110) checks FIFO order
        id_is_branch = 1'b0; ex_resolve = 1'b1; ex_taken = 1'b1;
        tick();
        ex_resolve = 1'b0;
        check("order_pc",    imem_addr, 32'h110);
        check("order_flush", flush_o,   32'h1);
        check("order_valid", if_valid,  32'h0);
        tick();
        check("order_flush_end", flush_o, 32'h0);

        // Reset asserted during a mispredict cycle
        id_is_branch = 1'b1; id_jmp = 1'b0; id_target = 32'h200;
        tick();
        id_is_branch = 1'b0; ex_resolve = 1'b1; ex_taken = 1'b1; rst = 1'b1;
        check("pre_rst_pc", imem_addr, 32'h118);
        tick();
        check("rst_mp_pc",    imem_addr,  32'h0);
        check("rst_mp_flush", flush_o,    32'h0);
        check("rst_mp_valid", if_valid,   32'h0);
        check("rst_mp_err",   pred_err_o, 32'h0);
        rst = 1'b0; ex_resolve = 1'b0; imem_rdata = 32'h99;
        tick();
        check("post_rst_flush", flush_o,      32'h0);
        check("post_rst_iaddr", if_inst_addr, 32'h0);
        check("post_rst_valid", if_valid,     32'h1);
        check("post_rst_pc",    imem_addr,    32'h4);

        // Queue was cleared by reset: a resolve now is an error
        ex_resolve = 1'b1; ex_taken = 1'b0;
        tick();
        ex_resolve = 1'b0;
        check("post_rst_empty", pred_err_o, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded by reset.
REQ-002 Parameter RQ_DEPTH, 4, depth of the prediction-record queue (power of two, >=2).
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset, synchronous and active-high.
REQ-005 Port stall_i, input, 1, hazard-unit hold: PC and IF/ID register keep their values.
REQ-006 Port imem_addr, output, 32, instruction-memory address, equal to the current PC.
REQ-007 Port imem_rdata, input, 32, instruction word for imem_addr, combinational in the same cycle.
REQ-008 Port id_jmp, input, 1, decode-stage redirect request from the branch/jump unit (JAL, or a conditional branch predicted taken).
REQ-009 Port id_is_branch, input, 1, the ID-stage instruction is a conditional branch (BEQ/BLT/BGE).
REQ-010 Port id_target, input, 32, decode-stage target address (ID PC + imm).
REQ-011 Port ex_resolve, input, 1, EX stage resolves the oldest outstanding conditional branch this cycle.
REQ-012 Port ex_taken, input, 1, actual outcome of the branch being resolved.
REQ-013 Port if_inst_addr, output, 32, IF/ID register: PC of the instruction handed to ID.
REQ-014 Port if_inst, output, 32, IF/ID register: instruction word handed to ID.
REQ-015 Port if_valid, output, 1, IF/ID register holds a real instruction (0 = bubble).
REQ-016 Port flush_o, output, 1, registered one-cycle pulse; on a mispredict, ID/EX squashes its contents.
REQ-017 Port stall_req_o, output, 1, combinational; the queue is full and a branch waits in ID.
REQ-018 Port pred_err_o, output, 1, sticky; ex_resolve was seen with the queue empty.

Function
REQ-019 Next-PC priority: mispredict -> queue head alt_addr; else stall_i or stall_req_o -> hold; else id_jmp && if_valid -> id_target; else PC+4 (32-bit wrap-around).
REQ-020 IF/ID register: on stall_i or stall_req_o, hold all fields; otherwise load {PC, imem_rdata} with if_valid=1.
REQ-021 IF/ID register: on mispredict, or on id_jmp with if_valid and no hold, load if_valid=0 (wrong-path fetch squashed).
REQ-022 ID-stage inputs are ignored whenever if_valid=0.
REQ-023 Prediction record = {pred_taken, alt_addr}.
REQ-024 Record contents: pred_taken=id_jmp; alt_addr=if_inst_addr+4 if predicted taken, else id_target.
REQ-025 Push when id_is_branch && if_valid && !stall_i && !full && !mispredict.
REQ-026 mispredict = ex_resolve && !empty && (ex_taken != head.pred_taken), combinational.
REQ-027 On ex_resolve && !empty, pop the head.
REQ-028 Simultaneous push and non-mispredict pop: both take effect, so occupancy is unchanged.
REQ-029 On mispredict, clear the whole queue (read ptr = write ptr, count=0), suppress any same-cycle push, and pulse flush_o the next cycle.
REQ-030 Mispredict overrides stall_i.
REQ-031 Full queue with a pushable branch in ID: stall_req_o=1, no push, PC and IF/ID held.
REQ-032 ex_resolve with an empty queue: no pop, no redirect, pred_err_o set until reset.
REQ-033 Queue pointers wrap modulo RQ_DEPTH.
REQ-034 Full/empty are derived from a count of width log2(RQ_DEPTH)+1.

Reset
REQ-035 While rst=1 at a clock edge: PC=RESET_PC, if_valid=0, if_inst=32'h0000_0013 (NOP), if_inst_addr=0, queue empty, flush_o=0, pred_err_o=0.
REQ-036 Reset overrides all other inputs, including a mid-flight mispredict.
REQ-037 First fetch at RESET_PC occurs in the first cycle after rst deasserts.

Structure
REQ-038 RESET_PC default, the NOP encoding and the prediction-record struct {pred_taken, alt_addr} live in the shared pipeline package used by branch_and_jmp.
REQ-039 The prediction queue is a sub-module pred_queue: synchronous FIFO with push, pop, clear, full, empty and a head read.

Verification
REQ-040 Sequential fetch: reset, then 3 cycles with imem returning 0x11,0x22,0x33 -> if_inst_addr 0,4,8 and if_valid=1 from the first edge after reset.
REQ-041 Taken prediction: branch at 0x10, id_jmp=1, id_target=0x40 -> next PC 0x40, one bubble, record {1,0x14} pushed.
REQ-042 Mispredict: head {1,0x14}, ex_resolve=1 with ex_taken=0 and stall_i=1 -> PC=0x14 next cycle, if_valid=0, flush_o pulses once, queue empty.
REQ-043 Queue full: 4 unresolved branches plus a 5th in ID -> stall_req_o=1, PC held; same cycle ex_resolve correct -> 5th pushed next cycle, count stays 4.
REQ-044 Error/reset: ex_resolve on an empty queue -> pred_err_o=1 and PC unaffected; rst asserted during a mispredict cycle -> PC=RESET_PC and flush_o=0.
